// File: rtl/clk_monitor_pkg.sv
// clk_monitor_pkg: state type and default parameters shared by the clock monitor.
package clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOST  = 2'd2
    } clk_mon_state_e;

    localparam int CLK_MON_CNT_W_DEFAULT   = 25;
    localparam int CLK_MON_TIMEOUT_DEFAULT = 20_000_000;

endpackage

// File: rtl/clk_monitor_edge_detect.sv
// edge_detect: delay flop plus registered rise/fall strobes; rise_det_o is the
// unregistered rise seen this cycle, used by the parent's counter and FSM.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic s_i,
    output logic rise_det_o,
    output logic rise_pulse_o,
    output logic fall_pulse_o
);

    logic s_prev_q, rise_q, fall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_prev_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s_prev_q <= s_i;
            rise_q   <= s_i & ~s_prev_q;
            fall_q   <= ~s_i & s_prev_q;
        end
    end

    assign rise_det_o   = s_i & ~s_prev_q;
    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;

endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: edge strobes, rise-to-rise period and loss detection for a slow clock.
// Define CLK_MON_SYNC_EN to insert a 2-flop synchronizer on slow_clk_in.
module clk_monitor
    import clk_monitor_pkg::*;
#(
    parameter int CNT_W   = CLK_MON_CNT_W_DEFAULT,
    parameter int TIMEOUT = CLK_MON_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             slow_clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period_count,
    output logic             period_valid,
    output logic             clk_lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             s, rise_det, at_timeout;
    clk_mon_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             valid_q, valid_d;

`ifdef CLK_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], slow_clk_in};
    end

    assign s = sync_q[1];
`else
    assign s = slow_clk_in;
`endif

    edge_detect u_edge_detect (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_i          (s),
        .rise_det_o   (rise_det),
        .rise_pulse_o (rise_pulse),
        .fall_pulse_o (fall_pulse)
    );

    assign at_timeout = cnt_q == TIMEOUT_C;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A rise wins over a timeout reached in the same cycle.
    always_comb begin
        state_d = rise_det ? ARMED : (at_timeout ? LOST : state_q);
    end

    always_comb begin
        clk_lost = state_q == LOST;
    end

    always_comb begin
        cnt_d    = rise_det ? CNT_W'(1) : (at_timeout ? cnt_q : cnt_q + 1'b1);
        valid_d  = rise_det && state_q == ARMED;
        period_d = valid_d ? cnt_q : period_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
        end
    end

    assign period_count = period_q;
    assign period_valid = valid_q;

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: random and directed slow-clock patterns checked every cycle
// against a timestamp-based reference model; honours CLK_MON_SYNC_EN latency.
module tb_clk_monitor;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 40;
`ifdef CLK_MON_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             slow_clk_in = 1'b0;
    logic             rise_pulse, fall_pulse, period_valid, clk_lost;
    logic [CNT_W-1:0] period_count;

    int n_checks = 0;
    int n_fail   = 0;

    // model: edge index since release, timestamp of last rise, input history
    int   n, last, e_period;
    logic sp, armed, lost, e_rise, e_fall, e_valid;
    logic vh[$];

    clk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .slow_clk_in  (slow_clk_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period_count (period_count),
        .period_valid (period_valid),
        .clk_lost     (clk_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; last = 1; e_period = 0;
        sp = 0; armed = 0; lost = 0;
        e_rise = 0; e_fall = 0; e_valid = 0;
        vh.delete();
    endtask

    task automatic model_edge(input logic v);
        logic s;
        n++;
        vh.push_back(v);
        s = (n - DLY >= 1) ? vh[n - DLY - 1] : 1'b0;
        e_rise  = s & ~sp;
        e_fall  = ~s & sp;
        e_valid = 0;
        sp = s;
        if (e_rise) begin
            if (armed && !lost) begin
                e_valid  = 1;
                e_period = n - last;
            end
            armed = 1;
            lost  = 0;
            last  = n;
        end else if (n - last >= TIMEOUT) begin
            lost = 1;
        end
    endtask

    task automatic cyc(input logic v);
        slow_clk_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
        check("rise_pulse", 32'(rise_pulse), 32'(e_rise));
        check("fall_pulse", 32'(fall_pulse), 32'(e_fall));
        check("period_valid", 32'(period_valid), 32'(e_valid));
        check("period_count", 32'(period_count), 32'(e_period));
        check("clk_lost", 32'(clk_lost), 32'(lost));
    endtask

    task automatic run(input logic v, input int cycles);
        repeat (cycles) cyc(v);
    endtask

    task automatic do_reset(input logic v);
        #2 reset_n = 1'b0;
        #1;
        check("rst_rise_pulse", 32'(rise_pulse), 0);
        check("rst_fall_pulse", 32'(fall_pulse), 0);
        check("rst_period_valid", 32'(period_valid), 0);
        check("rst_period_count", 32'(period_count), 0);
        check("rst_clk_lost", 32'(clk_lost), 0);
        slow_clk_in = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int h;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);
        // steady period 10
        repeat (8) begin run(1, 5); run(0, 5); end
        // period change to 24
        repeat (5) begin run(1, 12); run(0, 12); end
        // held low past timeout, then recovery
        run(1, 5); run(0, 50);
        repeat (3) begin run(1, 5); run(0, 5); end
        // rise exactly at the timeout count
        repeat (3) begin run(1, 20); run(0, 20); end
        // async reset mid-period, then no valid on the first rise
        run(1, 5); run(0, 2);
        do_reset(1'b0);
        repeat (3) begin run(1, 5); run(0, 5); end
        // input high at reset release
        run(1, 3);
        do_reset(1'b1);
        run(1, 4); run(0, 5);
        repeat (2) begin run(1, 5); run(0, 5); end
        // constant high and constant low from idle
        do_reset(1'b0);
        run(1, 60);
        do_reset(1'b0);
        run(0, 60);
        // random half periods, occasionally long enough to lose the clock
        for (int i = 0; i < 60; i++) begin
            h = ($urandom_range(9) == 0) ? int'($urandom_range(46, 39)) : int'($urandom_range(20, 1));
            run(1, h);
            h = ($urandom_range(9) == 0) ? int'($urandom_range(46, 39)) : int'($urandom_range(20, 1));
            run(0, h);
            if (i == 30) do_reset(1'($urandom_range(1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
